// File: rtl/seq_pkg.sv
// Shared types and default constants for the program sequencer.
package seq_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;

    localparam int DEF_NUM_PROGS = 3;
    localparam int DEF_START_CYC = 2;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_TIMEOUT   = 4096;
    localparam int PROG_W        = (DEF_NUM_PROGS > 1) ? $clog2(DEF_NUM_PROGS) : 1;

    typedef logic [PROG_W-1:0] prog_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en && (q != '1))
            q <= q + 1'b1;
    end
endmodule

// File: rtl/program_sequencer.sv
// Runs the core's resident programs in order via Start/Ack, timing each run.
module program_sequencer
    import seq_pkg::*;
#(
    parameter  int NUM_PROGS = DEF_NUM_PROGS,
    parameter  int START_CYC = DEF_START_CYC,
    parameter  int CNT_W     = DEF_CNT_W,
    parameter  int TIMEOUT   = DEF_TIMEOUT,
    localparam int PW        = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             Abort,
    input  logic             Ack,
    output logic             Start,
    output logic [PW-1:0]    ProgSel,
    output logic             Busy,
    output logic             ProgDone,
    output logic [PW-1:0]    ProgDoneIdx,
    output logic [CNT_W-1:0] CycleCount,
    output logic             AllDone,
    output logic             Err,
    output logic [PW-1:0]    ErrProg
);
    localparam int LW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

    state_t             state, state_n;
    logic [LW-1:0]      lcnt, lcnt_n;
    logic               acklow, acklow_n;
    logic               rc_clr, rc_en;
    logic [CNT_W-1:0]   rc_q, rc_inc;
    logic               start_n, done_n, all_n, err_n;
    logic [PW-1:0]      sel_n, idx_n, eprog_n;
    logic [CNT_W-1:0]   cyc_n;

    sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (rc_clr),
        .en    (rc_en),
        .q     (rc_q)
    );

    // CycleCount includes the cycle in which the qualifying Ack is sampled.
    assign rc_inc = (rc_q == '1) ? rc_q : rc_q + 1'b1;

    always_comb begin
        state_n  = state;
        start_n  = Start;
        sel_n    = ProgSel;
        done_n   = 1'b0;
        all_n    = 1'b0;
        idx_n    = ProgDoneIdx;
        cyc_n    = CycleCount;
        err_n    = Err;
        eprog_n  = ErrProg;
        lcnt_n   = lcnt;
        acklow_n = acklow;
        rc_clr   = 1'b0;
        rc_en    = 1'b0;
        if (state != IDLE && Abort) begin
            state_n = IDLE;
            start_n = 1'b0;
            err_n   = 1'b1;
            eprog_n = ProgSel;
        end else begin
            case (state)
                IDLE: if (Go) begin
                    state_n = LAUNCH;
                    start_n = 1'b1;
                    sel_n   = '0;
                    err_n   = 1'b0;
                    lcnt_n  = '0;
                end
                LAUNCH: if (lcnt == LW'(START_CYC - 1)) begin
                    state_n  = RUN;
                    start_n  = 1'b0;
                    rc_clr   = 1'b1;
                    acklow_n = 1'b0;
                end else begin
                    lcnt_n = lcnt + 1'b1;
                end
                RUN: begin
                    rc_en = 1'b1;
                    if (!Ack) acklow_n = 1'b1;
                    if (Ack && acklow) begin
                        state_n = REPORT;
                        done_n  = 1'b1;
                        idx_n   = ProgSel;
                        cyc_n   = rc_inc;
                        // Advance the index now so it settles a cycle before Start rises.
                        if (ProgSel == PW'(NUM_PROGS - 1)) all_n = 1'b1;
                        else                               sel_n = ProgSel + 1'b1;
                    end else if (TIMEOUT != 0 && rc_q == CNT_W'(TIMEOUT - 1)) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                        eprog_n = ProgSel;
                    end
                end
                REPORT: if (AllDone) begin
                    state_n = IDLE;
                end else begin
                    state_n = LAUNCH;
                    start_n = 1'b1;
                    lcnt_n  = '0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            lcnt        <= '0;
            acklow      <= 1'b0;
            Start       <= 1'b0;
            ProgSel     <= '0;
            Busy        <= 1'b0;
            ProgDone    <= 1'b0;
            ProgDoneIdx <= '0;
            CycleCount  <= '0;
            AllDone     <= 1'b0;
            Err         <= 1'b0;
            ErrProg     <= '0;
        end else begin
            state       <= state_n;
            lcnt        <= lcnt_n;
            acklow      <= acklow_n;
            Start       <= start_n;
            ProgSel     <= sel_n;
            Busy        <= (state_n != IDLE);
            ProgDone    <= done_n;
            ProgDoneIdx <= idx_n;
            CycleCount  <= cyc_n;
            AllDone     <= all_n;
            Err         <= err_n;
            ErrProg     <= eprog_n;
        end
    end
endmodule
